// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//
// Issue stage in front of the 64-bit execute ALU. Decodes the main-decoder
// ALU op class, funct3 and funct7[5] into the 4-bit ALU control code, then
// registers the decoded payload onto a valid/ready handshake. A two-entry
// store (output register + skid register) lets execute stall without any
// combinational path from out_ready to in_ready.
//
// Optional feature macro: ALU_ISSUE_PERF_EN
//   When defined, adds three 32-bit saturating counters (perf_issued,
//   perf_stall, perf_illegal). When undefined they and their ports are absent.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   flush                 synchronous flush: empties the stage, drops input
//   in_valid / in_ready   upstream handshake (in_ready is registered)
//   alu_op                00 ld/st, 01 branch, 10 R-type, 11 I-type
//   funct3, funct7_5      instruction fields used by the decode
//   in_rs1, in_rs2, in_rd operands and destination index
//   out_valid / out_ready downstream handshake to the ALU
//   out_rs1, out_rs2, out_rd, out_ctrl, out_funct3, out_illegal
//                         registered payload presented to the ALU
//   perf_issued, perf_stall, perf_illegal  (ALU_ISSUE_PERF_EN only)
// -----------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [RD_W-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1,
  output logic [XLEN-1:0] out_rs2,
  output logic [RD_W-1:0] out_rd,
  output logic [3:0]      out_ctrl,
  output logic [2:0]      out_funct3,
  output logic            out_illegal
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]     perf_issued,
  output logic [31:0]     perf_stall,
  output logic [31:0]     perf_illegal
`endif
);

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_XOR  = 4'b0011;
  localparam logic [3:0] CTRL_SLL  = 4'b0100;
  localparam logic [3:0] CTRL_SRL  = 4'b0101;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SRA  = 4'b0111;
  localparam logic [3:0] CTRL_SLT  = 4'b1000;
  localparam logic [3:0] CTRL_SLTU = 4'b1001;
  localparam logic [3:0] CTRL_ILL  = 4'b1111;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [RD_W-1:0] rd;
    logic [3:0]      ctrl;
    logic [2:0]      funct3;
    logic            illegal;
  } payload_t;

  state_t   state;
  payload_t out_q;
  payload_t skid_q;
  payload_t in_payload;
  logic [3:0] dec_ctrl;
  logic       dec_illegal;
  logic       accept;
  logic       drain;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  // NOTE: every output of an always_comb gets a default on entry; a path that
  // skips an assignment would otherwise infer a latch.
  always_comb begin
    dec_ctrl    = CTRL_ADD;
    dec_illegal = 1'b0;
    unique case (alu_op)
      2'b00: dec_ctrl = CTRL_ADD;
      2'b01: begin
        case (funct3)
          3'b000, 3'b001: dec_ctrl = CTRL_SUB;
          3'b100, 3'b101: dec_ctrl = CTRL_SLT;
          3'b110, 3'b111: dec_ctrl = CTRL_SLTU;
          default:        dec_illegal = 1'b1;
        endcase
      end
      default: begin
        // R-type (10) and I-type (11) share the table; I-type has no SUB, so
        // its funct7_5 (an immediate bit) is ignored for funct3=000.
        case (funct3)
          3'b000:  dec_ctrl = (funct7_5 && !alu_op[0]) ? CTRL_SUB : CTRL_ADD;
          3'b001:  dec_ctrl = CTRL_SLL;
          3'b010:  dec_ctrl = CTRL_SLT;
          3'b011:  dec_ctrl = CTRL_SLTU;
          3'b100:  dec_ctrl = CTRL_XOR;
          3'b101:  dec_ctrl = funct7_5 ? CTRL_SRA : CTRL_SRL;
          3'b110:  dec_ctrl = CTRL_OR;
          default: dec_ctrl = CTRL_AND;
        endcase
        if (funct7_5 && (funct3 != 3'b000) && (funct3 != 3'b101)) begin
          dec_illegal = 1'b1;
        end
      end
    endcase
    if (dec_illegal) begin
      dec_ctrl = CTRL_ILL;
    end
  end

  always_comb begin
    in_payload.rs1     = in_rs1;
    in_payload.rs2     = in_rs2;
    in_payload.rd      = in_rd;
    in_payload.ctrl    = dec_ctrl;
    in_payload.funct3  = funct3;
    in_payload.illegal = dec_illegal;
  end

  // ---------------------------------------------------------------------------
  // Output register + skid register
  // ---------------------------------------------------------------------------
  // A flush drops the incoming beat; an output beat on the same edge still
  // counts as delivered because the ALU sampled it.
  assign accept = in_valid && in_ready && !flush;
  assign drain  = out_valid && out_ready;

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values; the payload registers are reset only to keep traces
  // X-free, the handshake logic never depends on their contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_q     <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_q     <= in_payload;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            out_q <= in_payload;
          end else if (accept) begin
            skid_q   <= in_payload;
            in_ready <= 1'b0;
            state    <= FULL;
          end else if (drain) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so no new beat can arrive alongside.
          if (drain) begin
            out_q    <= skid_q;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_rd      = out_q.rd;
  assign out_ctrl    = out_q.ctrl;
  assign out_funct3  = out_q.funct3;
  assign out_illegal = out_q.illegal;

`ifdef ALU_ISSUE_PERF_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters (not cleared by flush)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued  <= '0;
      perf_stall   <= '0;
      perf_illegal <= '0;
    end else begin
      if (drain && (perf_issued != '1)) begin
        perf_issued <= perf_issued + 32'd1;
      end
      if (out_valid && !out_ready && (perf_stall != '1)) begin
        perf_stall <= perf_stall + 32'd1;
      end
      if (drain && out_q.illegal && (perf_illegal != '1)) begin
        perf_illegal <= perf_illegal + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Self-checking bench for alu_issue_stage. A queue-based reference model (at
// most two beats in flight, in-order delivery) tracks what the stage must be
// holding; a compare process checks the DUT against it on every falling edge.
// Directed sections pin the model with hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

  localparam int XLEN = 64;
  localparam int RD_W = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      alu_op = '0;
  logic [2:0]      funct3 = '0;
  logic            funct7_5 = 1'b0;
  logic [XLEN-1:0] in_rs1 = '0;
  logic [XLEN-1:0] in_rs2 = '0;
  logic [RD_W-1:0] in_rd = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_rs1;
  logic [XLEN-1:0] out_rs2;
  logic [RD_W-1:0] out_rd;
  logic [3:0]      out_ctrl;
  logic [2:0]      out_funct3;
  logic            out_illegal;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0]     perf_issued;
  logic [31:0]     perf_stall;
  logic [31:0]     perf_illegal;
`endif

  alu_issue_stage #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_rd     (out_rd),
    .out_ctrl   (out_ctrl),
    .out_funct3 (out_funct3),
    .out_illegal(out_illegal)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall),
    .perf_illegal(perf_illegal)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference decode, written straight from the control-code table
  // ---------------------------------------------------------------------------
  function automatic logic [4:0] ref_decode(input logic [1:0] op, input logic [2:0] f3,
                                            input logic f7);
    logic [3:0] rtab [0:7];
    rtab[0] = 4'b0010; rtab[1] = 4'b0100; rtab[2] = 4'b1000; rtab[3] = 4'b1001;
    rtab[4] = 4'b0011; rtab[5] = 4'b0101; rtab[6] = 4'b0001; rtab[7] = 4'b0000;
    if (op == 2'b00) return {1'b0, 4'b0010};
    if (op == 2'b01) begin
      if (f3 == 3'b010 || f3 == 3'b011) return 5'b11111;
      if (f3 <= 3'b001) return {1'b0, 4'b0110};
      if (f3 <= 3'b101) return {1'b0, 4'b1000};
      return {1'b0, 4'b1001};
    end
    if (f3 == 3'b000) return {1'b0, (f7 && op == 2'b10) ? 4'b0110 : 4'b0010};
    if (f3 == 3'b101) return {1'b0, f7 ? 4'b0111 : 4'b0101};
    if (f7) return 5'b11111;
    return {1'b0, rtab[f3]};
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: an in-order queue holding at most two beats
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [RD_W-1:0] rd;
    logic [2:0]      f3;
    logic [3:0]      ctrl;
    logic            ill;
  } beat_t;

  beat_t q[$];
  int    m_size;
  int    n_xfer = 0;
  int    m_issued = 0;
  int    m_stall = 0;
  int    m_illegal = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_issued  = 0;
      m_stall   = 0;
      m_illegal = 0;
    end else begin
      m_size = q.size();
      if (m_size > 0 && !out_ready) m_stall++;
      if (m_size > 0 && out_ready) begin
        n_xfer++;
        m_issued++;
        if (q[0].ill) m_illegal++;
        void'(q.pop_front());
      end
      if (flush) begin
        q.delete();
      end else if (in_valid && m_size < 2) begin
        beat_t b;
        logic [4:0] d;
        d = ref_decode(alu_op, funct3, funct7_5);
        b.rs1 = in_rs1; b.rs2 = in_rs2; b.rd = in_rd; b.f3 = funct3;
        b.ctrl = d[3:0]; b.ill = d[4];
        q.push_back(b);
      end
    end
  end

  // Compare process: outputs are stable from just after the rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", 64'(in_ready), 64'(q.size() < 2));
      check("out_valid", 64'(out_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
        check("out_rs1", out_rs1, q[0].rs1);
        check("out_rs2", out_rs2, q[0].rs2);
        check("out_rd", 64'(out_rd), 64'(q[0].rd));
        check("out_funct3", 64'(out_funct3), 64'(q[0].f3));
        check("out_ctrl", 64'(out_ctrl), 64'(q[0].ctrl));
        check("out_illegal", 64'(out_illegal), 64'(q[0].ill));
      end
`ifdef ALU_ISSUE_PERF_EN
      check("perf_issued", 64'(perf_issued), 64'(m_issued));
      check("perf_stall", 64'(perf_stall), 64'(m_stall));
      check("perf_illegal", 64'(perf_illegal), 64'(m_illegal));
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f3,
                       input logic f7, input logic [RD_W-1:0] rd);
    in_valid = v;
    alu_op   = op;
    funct3   = f3;
    funct7_5 = f7;
    in_rd    = rd;
    in_rs1   = {$urandom(), $urandom()};
    in_rs2   = {$urandom(), $urandom()};
  endtask

  task automatic pin(input string name, input logic [1:0] op, input logic [2:0] f3,
                     input logic f7, input logic [3:0] exp_ctrl, input logic exp_ill);
    drive(1'b1, op, f3, f7, 5'd9);
    out_ready = 1'b1;
    @(negedge clk);
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_ctrl"}, 64'(out_ctrl), 64'(exp_ctrl));
    check({name, "_illegal"}, 64'(out_illegal), 64'(exp_ill));
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int start_xfer;
    int cyc;

    // Reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_rs1", out_rs1, 64'd0);
    check("rst_out_rs2", out_rs2, 64'd0);
    check("rst_out_rd", 64'(out_rd), 64'd0);
    check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    check("rst_out_funct3", 64'(out_funct3), 64'd0);
    check("rst_out_illegal", 64'(out_illegal), 64'd0);

    // R-type SUB, latency 1
    drive(1'b1, 2'b10, 3'b000, 1'b1, 5'd7);
    in_rs1 = 64'd10;
    in_rs2 = 64'd3;
    out_ready = 1'b1;
    @(negedge clk);
    check("sub_valid", 64'(out_valid), 64'd1);
    check("sub_ctrl", 64'(out_ctrl), 64'b0110);
    check("sub_rs1", out_rs1, 64'd10);
    check("sub_rs2", out_rs2, 64'd3);
    in_valid = 1'b0;
    @(negedge clk);
    check("sub_drained", 64'(out_valid), 64'd0);

    // Hand-computed decode pins
    pin("i_sra", 2'b11, 3'b101, 1'b1, 4'b0111, 1'b0);
    pin("br_sltu", 2'b01, 3'b110, 1'b0, 4'b1001, 1'b0);
    pin("r_xor_f7", 2'b10, 3'b100, 1'b1, 4'b1111, 1'b1);
    pin("i_add_f7", 2'b11, 3'b000, 1'b1, 4'b0010, 1'b0);
    pin("i_sll_f7", 2'b11, 3'b001, 1'b1, 4'b1111, 1'b1);
    pin("br_010", 2'b01, 3'b010, 1'b0, 4'b1111, 1'b1);
    pin("ls_any", 2'b00, 3'b111, 1'b1, 4'b0010, 1'b0);

    // Full decode sweep at throughput 1
    out_ready = 1'b1;
    for (int op = 0; op < 4; op++) begin
      for (int f3 = 0; f3 < 8; f3++) begin
        for (int f7 = 0; f7 < 2; f7++) begin
          drive(1'b1, op[1:0], f3[2:0], f7[0], RD_W'(f3));
          @(negedge clk);
        end
      end
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Back-to-back with the consumer stalled
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 3'b000, 1'b0, 5'd1);
    @(negedge clk);
    check("b2b_ready_after1", 64'(in_ready), 64'd1);
    drive(1'b1, 2'b10, 3'b000, 1'b0, 5'd2);
    @(negedge clk);
    check("b2b_ready_after2", 64'(in_ready), 64'd0);
    drive(1'b1, 2'b10, 3'b000, 1'b0, 5'd3);
    @(negedge clk);
    check("b2b_held_ready", 64'(in_ready), 64'd0);
    check("b2b_head_rd1", 64'(out_rd), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("b2b_rd2", 64'(out_rd), 64'd2);
    @(negedge clk);
    check("b2b_rd3", 64'(out_rd), 64'd3);
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_empty", 64'(out_valid), 64'd0);

    // Flush while FULL with a simultaneous input
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 3'b000, 1'b0, 5'd4);
    @(negedge clk);
    drive(1'b1, 2'b00, 3'b000, 1'b0, 5'd5);
    @(negedge clk);
    check("fl_full", 64'(in_ready), 64'd0);
    drive(1'b1, 2'b00, 3'b000, 1'b0, 5'd31);
    flush = 1'b1;
    @(negedge clk);
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("fl_dropped", 64'(out_valid), 64'd0);
    end

    // Random traffic
    start_xfer = n_xfer;
    cyc = 0;
    while ((n_xfer - start_xfer) < 10000 && cyc < 60000) begin
      drive($urandom_range(0, 99) < 80, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), RD_W'($urandom_range(0, 31)));
      out_ready = $urandom_range(0, 99) < 75;
      flush = $urandom_range(0, 199) == 0;
      @(negedge clk);
      cyc++;
    end
    check("rand_xfers_done", 64'((n_xfer - start_xfer) >= 10000), 64'd1);
    flush = 1'b0;

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 3'b000, 1'b0, 5'd6);
    @(negedge clk);
    drive(1'b1, 2'b10, 3'b000, 1'b0, 5'd7);
    @(negedge clk);
    drive(1'b1, 2'b10, 3'b000, 1'b0, 5'd8);
    @(negedge clk);
    check("ar_full", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", 64'(out_valid), 64'd0);
    check("ar_in_ready", 64'(in_ready), 64'd1);
    check("ar_out_rd", 64'(out_rd), 64'd0);
`ifdef ALU_ISSUE_PERF_EN
    check("ar_perf_issued", 64'(perf_issued), 64'd0);
    check("ar_perf_stall", 64'(perf_stall), 64'd0);
    check("ar_perf_illegal", 64'(perf_illegal), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ar_after_valid", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Issue stage that drives the 64-bit execute ALU.
- Decodes the main-decoder ALUOp, funct3 and funct7[5] into the 4-bit ALU control code.
- Registers the operand pair and destination onto a valid/ready handshake, with a 2-entry skid buffer so the execute stage can stall without combinational ready paths.
- Sits between the ID/operand-read stage and the ALU.

Parameters:
XLEN, 64, operand width in bits.
RD_W, 5, destination register index width.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
flush  input  1  synchronous pipeline flush.
in_valid  input  1  upstream payload valid.
in_ready  output  1  stage can accept (registered).
alu_op  input  2  00 load/store, 01 branch, 10 R-type, 11 I-type.
funct3  input  3  instruction funct3.
funct7_5  input  1  instruction bit 30.
in_rs1  input  XLEN  operand A.
in_rs2  input  XLEN  operand B or immediate.
in_rd  input  RD_W  destination index.
out_valid  output  1  payload valid to ALU.
out_ready  input  1  ALU/execute accepts.
out_rs1  output  XLEN  registered operand A.
out_rs2  output  XLEN  registered operand B.
out_rd  output  RD_W  registered destination.
out_ctrl  output  4  ALU control code.
out_funct3  output  3  funct3 passthrough, used for branch resolution.
out_illegal  output  1  decode illegal.

Behaviour:
- Control codes: AND=0000, OR=0001, ADD=0010, XOR=0011, SLL=0100, SRL=0101, SUB=0110, SRA=0111, SLT=1000, SLTU=1001, illegal=1111.
- alu_op 00: ADD, regardless of funct3/funct7_5.
- alu_op 01 (branch):
  - funct3 000/001 -> SUB.
  - 100/101 -> SLT.
  - 110/111 -> SLTU.
  - 010/011 -> illegal.
- alu_op 10 (R-type):
  - 000 -> ADD, or SUB if funct7_5.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
  - 101 -> SRL, or SRA if funct7_5.
  - 110 OR, 111 AND.
  - funct7_5=1 with funct3 not in {000,101} -> illegal.
- alu_op 11 (I-type): same as R-type, except:
  - 000 is always ADD.
  - 001 with funct7_5=1 -> illegal.
- Illegal decode: out_ctrl=1111 and out_illegal=1; the payload still flows.
- Transfer rules: a transfer occurs on the edge where valid&&ready. Accepted input appears on the out_* ports the next cycle (latency 1). Throughput is 1 per cycle while out_ready=1.
- Storage: output register plus one skid register. States EMPTY, ONE, FULL (skid occupied).
  - EMPTY + accept -> ONE.
  - ONE + accept + no drain -> FULL (payload into skid).
  - ONE + accept + drain -> ONE (output reloaded).
  - ONE + drain, no accept -> EMPTY.
  - FULL + drain -> ONE (skid moves to output).
- in_ready = (state != FULL); registered, never a function of out_ready.
- out_* are stable while out_valid=1 and out_ready=0.
- flush: next state EMPTY and in_ready=1. A simultaneous in_valid is dropped; any simultaneous output transfer still completes.
- Reset (async assert, sync deassert at the system level):
  - out_valid=0, in_ready=1.
  - out_rs1/out_rs2/out_rd/out_funct3=0, out_ctrl=0000, out_illegal=0.
  - state EMPTY.
- Payload registers need no reset for function but are reset for X-free traces.

Optional Feature:
ALU_ISSUE_PERF_EN
- Defined: three 32-bit saturating counters are added, exposed as outputs perf_issued, perf_stall and perf_illegal.
  - perf_issued: output transfers.
  - perf_stall: cycles with out_valid && !out_ready.
  - perf_illegal: issued payloads with out_illegal.
  - Counters reset to 0 on rst_n and saturate at 0xFFFFFFFF. flush does not clear them.
- Undefined: the counters and their ports are absent; all other behaviour is identical.

Test Plan:
- R-type funct3=000, funct7_5=1, rs1=10, rs2=3, out_ready=1 -> next cycle out_valid=1, out_ctrl=0110, out_rs1=10, out_rs2=3; one cycle later out_valid=0.
- Sweep all alu_op/funct3/funct7_5 combinations -> out_ctrl matches the table. Examples: I-type 101/1 -> 0111; branch 110 -> 1001; R-type 100/1 -> 1111 with out_illegal=1.
- Three back-to-back inputs (rd=1,2,3) with out_ready=0 for 3 cycles:
  - in_ready falls after the 2nd accept; the 3rd input is held.
  - After release, outputs in order rd=1,2,3 with no loss or duplication.
- Random valid/ready, 10k transfers -> scoreboard order and payload match; out_* stable under stall.
- FULL state, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped input never appears.
- rst_n low mid-stream with FULL and out_valid=1 -> immediately out_valid=0 and in_ready=1. With ALU_ISSUE_PERF_EN: perf_* = 0.
